// File: rtl/line_buffer.sv
// line_buffer
//   Streaming sliding-window generator. Pixels arrive in raster order, one per
//   valid/ready handshake. The block keeps the last BLOCK_HEIGHT-1 lines plus
//   BLOCK_WIDTH pixels and, once primed, presents a BLOCK_HEIGHT x BLOCK_WIDTH
//   window on every accepted pixel through a single output register.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-low reset
//   p_valid   in   upstream pixel valid
//   pixel     in   input pixel
//   p_ready   out  block can accept a pixel this cycle
//   k_valid   out  kernel/k_border hold a window
//   k_ready   in   downstream accepts the window
//   kernel    out  packed window, (row i, col j) at
//                  [i*BLOCK_WIDTH*BUFFER_WIDTH + j*BUFFER_WIDTH +: BUFFER_WIDTH];
//                  row 0 = oldest line, col 0 = oldest pixel
//   k_border  out  window wraps across a line boundary
module line_buffer #(
  parameter int BUFFER_WIDTH = 8,
  parameter int BUFFER_DEPTH = 9,
  parameter int BLOCK_WIDTH  = 3,
  parameter int BLOCK_HEIGHT = 3,
  localparam int OUTPUT_WIDTH = BLOCK_WIDTH * BLOCK_HEIGHT * BUFFER_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p_valid,
  input  logic [BUFFER_WIDTH-1:0] pixel,
  output logic                    p_ready,
  output logic                    k_valid,
  input  logic                    k_ready,
  output logic [OUTPUT_WIDTH-1:0] kernel,
  output logic                    k_border
);

  localparam int CHAIN_LEN = (BLOCK_HEIGHT - 1) * BUFFER_DEPTH + BLOCK_WIDTH;
  // The newest chain element is the incoming pixel itself, so only the older
  // CHAIN_LEN-1 pixels need storage; the rest of the window lives in kernel_q.
  localparam int STORE_LEN = CHAIN_LEN - 1;
  localparam int CW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int LW = $clog2(BLOCK_HEIGHT);

  localparam logic [CW-1:0] COL_LAST  = CW'(BUFFER_DEPTH - 1);
  localparam logic [CW-1:0] COL_PRIME = CW'(BLOCK_WIDTH - 1);
  localparam logic [LW-1:0] LINE_MAX  = LW'(BLOCK_HEIGHT - 1);

  logic [BUFFER_WIDTH-1:0] chain_q [STORE_LEN];
  logic [BUFFER_WIDTH-1:0] chain_d [CHAIN_LEN];
  logic [CW-1:0]           col_q, col_d;
  logic [LW-1:0]           line_q, line_d;
  logic                    primed_q;
  logic                    k_valid_q, k_valid_d;
  logic                    k_border_q, k_border_d;
  logic [OUTPUT_WIDTH-1:0] kernel_q, kernel_d;

  logic accept;
  logic col_last;
  logic prime_now;
  logic fire;

  assign p_ready  = !k_valid_q || k_ready;
  assign accept   = p_valid && p_ready;
  assign k_valid  = k_valid_q;
  assign k_border = k_border_q;
  assign kernel   = kernel_q;

  always_comb begin
    chain_d[0] = pixel;
    for (int k = 1; k < CHAIN_LEN; k++) begin
      chain_d[k] = chain_q[k-1];
    end
  end

  always_comb begin
    col_last  = (col_q == COL_LAST);
    col_d     = col_last ? '0 : col_q + 1'b1;
    line_d    = (col_last && (line_q != LINE_MAX)) ? line_q + 1'b1 : line_q;
    prime_now = (line_q == LINE_MAX) && (col_q == COL_PRIME);
    fire      = accept && (primed_q || prime_now);

    kernel_d = kernel_q;
    k_border_d = k_border_q;
    k_valid_d  = k_valid_q;
    if (fire) begin
      for (int i = 0; i < BLOCK_HEIGHT; i++) begin
        for (int j = 0; j < BLOCK_WIDTH; j++) begin
          kernel_d[i*BLOCK_WIDTH*BUFFER_WIDTH + j*BUFFER_WIDTH +: BUFFER_WIDTH] =
            chain_d[(BLOCK_HEIGHT-1-i)*BUFFER_DEPTH + (BLOCK_WIDTH-1-j)];
        end
      end
      // col_q is the column of the pixel being accepted
      k_border_d = (int'(col_q) < BLOCK_WIDTH - 1);
      k_valid_d  = 1'b1;
    end else if (k_ready) begin
      k_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < STORE_LEN; k++) begin
        chain_q[k] <= '0;
      end
      col_q      <= '0;
      line_q     <= '0;
      primed_q   <= 1'b0;
      k_valid_q  <= 1'b0;
      k_border_q <= 1'b0;
      kernel_q   <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < STORE_LEN; k++) begin
          chain_q[k] <= chain_d[k];
        end
        col_q  <= col_d;
        line_q <= line_d;
        if (prime_now) begin
          primed_q <= 1'b1;
        end
      end
      k_valid_q  <= k_valid_d;
      k_border_q <= k_border_d;
      kernel_q   <= kernel_d;
    end
  end

endmodule

// File: tb/tb_line_buffer.sv
module tb_line_buffer;

  localparam int BW    = 8;
  localparam int D     = 9;
  localparam int W     = 3;
  localparam int H     = 3;
  localparam int OW    = W * H * BW;
  localparam int PRIME = (H - 1) * D + W;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_valid;
  logic [BW-1:0] pixel;
  logic          p_ready;
  logic          k_valid;
  logic          k_ready;
  logic [OW-1:0] kernel;
  logic          k_border;

  always #5 clk = ~clk;

  line_buffer #(
    .BUFFER_WIDTH(BW),
    .BUFFER_DEPTH(D),
    .BLOCK_WIDTH (W),
    .BLOCK_HEIGHT(H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .p_valid (p_valid),
    .pixel   (pixel),
    .p_ready (p_ready),
    .k_valid (k_valid),
    .k_ready (k_ready),
    .kernel  (kernel),
    .k_border(k_border)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: full accept history since reset, window read by offset
  logic [BW-1:0] hist[$];
  int            m_n;
  logic          m_kv;
  logic          m_border;
  logic [OW-1:0] m_kern;

  typedef struct {
    logic          pv;
    logic [BW-1:0] px;
    logic          exp_kv;
    logic          exp_border;
  } vec_t;

  vec_t tv[33];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chkk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [OW-1:0] model_window();
    logic [OW-1:0] w;
    int o;
    w = '0;
    for (int i = 0; i < H; i++) begin
      for (int j = 0; j < W; j++) begin
        o = (H - 1 - i) * D + (W - 1 - j);
        w[i*W*BW + j*BW +: BW] = hist[hist.size() - 1 - o];
      end
    end
    return w;
  endfunction

  // window formed by the first 21 accepts q0..q20 with q_k = b + k
  function automatic logic [OW-1:0] first_win(input logic [BW-1:0] b);
    return {b + 8'd20, b + 8'd19, b + 8'd18,
            b + 8'd11, b + 8'd10, b + 8'd9,
            b + 8'd2,  b + 8'd1,  b};
  endfunction

  task automatic model_reset();
    hist.delete();
    m_n      = 0;
    m_kv     = 1'b0;
    m_border = 1'b0;
    m_kern   = '0;
  endtask

  // One clock: drive, check p_ready mid-cycle, advance model, check outputs after the edge.
  task automatic cycle(input logic pv, input logic [BW-1:0] px, input logic kr, input logic rv);
    logic acc;
    rst     = rv;
    p_valid = pv;
    pixel   = px;
    k_ready = kr;
    #1;
    chk1("p_ready", p_ready, !m_kv || kr);
    acc = pv && (!m_kv || kr);
    if (!rv) begin
      model_reset();
    end else begin
      if (acc) begin
        hist.push_back(px);
        if (hist.size() > 64) void'(hist.pop_front());
        m_n++;
      end
      if (acc && m_n >= PRIME) begin
        m_kv     = 1'b1;
        m_border = ((m_n - 1) % D) < (W - 1);
        m_kern   = model_window();
      end else if (kr) begin
        m_kv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk1("k_valid", k_valid, m_kv);
    chk1("k_border", k_border, m_border);
    chkk("kernel", kernel, m_kern);
  endtask

  function automatic vec_t mk(input logic pv, input logic [BW-1:0] px,
                              input logic kv, input logic b);
    vec_t v;
    v.pv = pv; v.px = px; v.exp_kv = kv; v.exp_border = b;
    return v;
  endfunction

  initial begin : main
    int borders;
    logic [OW-1:0] w29;

    for (int k = 0; k < 21; k++) tv[k] = mk(1'b1, BW'(8'h10 + k), (k == 20), 1'b0);
    tv[21] = mk(1'b1, 8'h25, 1'b1, 1'b0);
    tv[22] = mk(1'b1, 8'h26, 1'b1, 1'b0);
    tv[23] = mk(1'b0, 8'hEE, 1'b0, 1'b0);
    tv[24] = mk(1'b1, 8'h27, 1'b1, 1'b0);
    tv[25] = mk(1'b1, 8'h28, 1'b1, 1'b0);
    tv[26] = mk(1'b0, 8'hEE, 1'b0, 1'b0);
    tv[27] = mk(1'b1, 8'h29, 1'b1, 1'b0);
    tv[28] = mk(1'b1, 8'h2A, 1'b1, 1'b0);
    tv[29] = mk(1'b1, 8'h2B, 1'b1, 1'b1);
    tv[30] = mk(1'b0, 8'hEE, 1'b0, 1'b0);
    tv[31] = mk(1'b1, 8'h2C, 1'b1, 1'b1);
    tv[32] = mk(1'b1, 8'h2D, 1'b1, 1'b0);
    w29 = {8'h2D, 8'h2C, 8'h2B, 8'h24, 8'h23, 8'h22, 8'h1B, 8'h1A, 8'h19};

    rst = 1'b0; p_valid = 1'b0; pixel = '0; k_ready = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    cycle(1'b0, 8'h00, 1'b1, 1'b1);

    // first fill, first window, bubbles and line-wrap borders
    for (int i = 0; i < 33; i++) begin
      cycle(tv[i].pv, tv[i].px, 1'b1, 1'b1);
      chk1("tbl_k_valid", k_valid, tv[i].exp_kv);
      if (tv[i].exp_kv) chk1("tbl_k_border", k_border, tv[i].exp_border);
      chk1("tbl_p_ready", p_ready, 1'b1);
      if (i == 20) chkk("first_window", kernel, first_win(8'h10));
      if (i == 32) chkk("window_p29", kernel, w29);
    end

    // backpressure: window held, no accepts
    for (int i = 0; i < 5; i++) begin
      cycle(1'($urandom_range(0, 1)), BW'($urandom), 1'b0, 1'b1);
      chkk("hold_kernel", kernel, w29);
      chk1("hold_p_ready", p_ready, 1'b0);
      chk1("hold_k_border", k_border, 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk1("release_consumed", k_valid, 1'b0);
    cycle(1'b1, 8'h2E, 1'b1, 1'b1);
    chkk("window_p30", kernel,
         {8'h2E, 8'h2D, 8'h2C, 8'h25, 8'h24, 8'h23, 8'h1C, 8'h1B, 8'h1A});
    chk1("window_p30_valid", k_valid, 1'b1);

    // 8 accepts, 5 idle, 20 accepts
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, BW'(8'h40 + k), 1'b1, 1'b1);
      chk1("gap_pre_kv", k_valid, 1'b0);
    end
    for (int k = 0; k < 5; k++) cycle(1'b0, 8'hAA, 1'b1, 1'b1);
    for (int k = 8; k < 28; k++) begin
      cycle(1'b1, BW'(8'h40 + k), 1'b1, 1'b1);
      if (k < 20) chk1("gap_fill_kv", k_valid, 1'b0);
      if (k == 20) chkk("gap_first_window", kernel, first_win(8'h40));
    end

    // mid-stream reset after 25 accepts
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 25; k++) cycle(1'b1, BW'(8'h60 + k), 1'b1, 1'b1);
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    chk1("rst_k_valid", k_valid, 1'b0);
    chk1("rst_k_border", k_border, 1'b0);
    chkk("rst_kernel", kernel, '0);
    for (int k = 0; k < 21; k++) begin
      cycle(1'b1, BW'(8'h80 + k), 1'b1, 1'b1);
      chk1("refill_kv", k_valid, (k == 20));
    end
    chkk("refill_window", kernel, first_win(8'h80));

    // 27 accepts past priming: borders on exactly 2 of every 9 windows
    borders = 0;
    for (int k = 0; k < 27; k++) begin
      cycle(1'b1, BW'($urandom), 1'b1, 1'b1);
      if (k_border) borders++;
    end
    chki("border_count", borders, 6);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), BW'($urandom), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 499) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/line_buffer.md
# line_buffer

Streaming sliding-window generator for the HOG pre-processing path. It accepts one pixel per handshake in raster order and keeps the last BLOCK_HEIGHT-1 image lines plus BLOCK_WIDTH pixels. On every accepted pixel it presents a BLOCK_HEIGHT x BLOCK_WIDTH window (kernel) to the downstream gradient/kernel stage. Both sides use valid/ready handshakes, so upstream and downstream stalls are both supported.

## Interface
- BUFFER_WIDTH, 8: bits per pixel.
- BUFFER_DEPTH, 9: pixels per image line (line length); must be ≥ BLOCK_WIDTH.
- BLOCK_WIDTH, 3: window columns; ≥1.
- BLOCK_HEIGHT, 3: window rows; ≥2.
- OUTPUT_WIDTH, BLOCK_WIDTH*BLOCK_HEIGHT*BUFFER_WIDTH: kernel bus width (derived, not overridden).
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- p_valid  in  1  upstream pixel valid.
- pixel  in  BUFFER_WIDTH  input pixel, raster order.
- p_ready  out  1  block can accept a pixel this cycle.
- k_valid  out  1  kernel/k_border hold a window.
- k_ready  in  1  downstream accepts the window.
- kernel  out  OUTPUT_WIDTH  packed window; element (row i, col j) at bits [i*BLOCK_WIDTH*BUFFER_WIDTH + j*BUFFER_WIDTH +: BUFFER_WIDTH]. Row 0 is the oldest line (top). Col 0 is the oldest pixel (left).
- k_border  out  1  window wraps across a line boundary (not a geometrically valid window).

## Operation
- Storage is a shift chain of (BLOCK_HEIGHT-1)*BUFFER_DEPTH+BLOCK_WIDTH pixels.
  - An accept (p_valid && p_ready) shifts pixel into the chain.
  - Row i, col j of the window = the pixel accepted (BLOCK_HEIGHT-1-i)*BUFFER_DEPTH + (BLOCK_WIDTH-1-j) accepts before the newest pixel.
- col counter: 0..BUFFER_DEPTH-1. Increments per accept; wraps to 0 after BUFFER_DEPTH-1.
- line counter: counts completed lines and saturates at BLOCK_HEIGHT-1. The stream is continuous; there is no frame boundary, and counters clear only on reset.
- primed flag:
  - Set on the accept where line counter == BLOCK_HEIGHT-1 and col == BLOCK_WIDTH-1, i.e. the first full window.
  - Stays set until reset.
- When an accept occurs with primed already set, or setting on that accept:
  - The output register loads the window including the new pixel.
  - k_valid is set to 1.
  - k_border is set to (col of new pixel < BLOCK_WIDTH-1).
- Accepts before priming only fill the chain; k_valid stays 0.
- p_ready = !k_valid || k_ready (combinational). The output register is a single skid-free stage.
- If k_valid && k_ready with no new accept in the same cycle, k_valid clears next cycle.
- While k_valid && !k_ready:
  - kernel and k_border are held stable.
  - p_ready=0, and the chain does not shift.
- Reset (rst=0 at a clock edge):
  - Chain, counters and primed clear to 0.
  - k_valid=0, k_border=0, kernel=0.
  - p_ready=1 after reset is released.
  - Mid-stream reset discards all buffered lines; the block must refill before the next window.

## Timing
- Latency: 1 cycle. The window containing the pixel accepted at edge N is visible after edge N (k_valid=1 from edge N onward).
- Throughput: 1 pixel/cycle with k_ready held 1.
- p_valid=0 cycles: no shift, no counter change. An already-presented window is consumed normally.
- p_valid dropping mid-line has no effect on window alignment; only accepts count.
- Simultaneous consume and accept: the output register reloads with the new window, and k_valid stays 1.
- First window for the defaults (9/3/3) appears after accept #21 (2*9+3).

## Test plan
- Reset, then stream 21 pixels p0..p20 with k_ready=1, p_valid=1:
  - k_valid rises only after accept #21, with k_border=0.
  - Rows are {p0,p1,p2}, {p9,p10,p11}, {p18,p19,p20}.
  - p_ready=1 throughout.
- Continue with p21..p29 (bubbles of p_valid=0 inserted mid-line):
  - Windows after p27 and p28 have k_border=1.
  - Window after p29 has k_border=0, with rows {p9..p11}, {p18..p20}, {p27..p29}.
  - No k_valid pulse occurs during bubbles after consumption.
- Backpressure: hold k_ready=0 after a window appears.
  - p_ready=0; kernel is unchanged for 5 cycles regardless of pixel/p_valid.
  - Release: the held window is consumed, then the next accepted pixel produces the correct next window with no lost or duplicated pixel.
- 8 accepts, 5 idle cycles, then 20 accepts:
  - The first window equals the first-21-accepts window.
  - The idle gap does not shift alignment.
- Assert rst=0 mid-stream (after 25 accepts):
  - Next cycle k_valid=0, kernel=0, k_border=0.
  - A new window appears only after 21 further accepts.
- Line wrap: after 3*9 accepts past priming, the col counter is back at the same phase, and k_border asserts on exactly 2 of every 9 windows (cols 0 and 1).
